// File: rtl/push_button_debouncer.sv
// Multi-channel push-button conditioner: 2-FF synchroniser, tick-sampled debounce, press/release pulses.
// Optional long-press detection is built when PB_LONG_PRESS_EN is defined; otherwise long_o is tied low.
module push_button_debouncer #(
    parameter int N_CH       = 4,
    parameter int CLK_HZ     = 100000000,
    parameter int TICK_HZ    = 1000,
    parameter int STABLE_CNT = 20,
    parameter int ACTIVE_LOW = 0,
    parameter int LONG_CNT   = 1000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_CH-1:0] push_b,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] long_o,
    output logic            tick_o
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNT_W = $clog2(STABLE_CNT + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [N_CH-1:0]  POLARITY = (ACTIVE_LOW != 0) ? '1 : '0;

    if (N_CH < 1 || N_CH > 32 || DIV < 2 || STABLE_CNT < 1 || LONG_CNT < 1) begin : g_param_err
        $error("push_button_debouncer: parameter out of range");
    end

    // Shared prescaler; tick_o is a registered one-cycle clock enable, never a clock.
    logic [DIV_W-1:0] div_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt <= '0;
            tick_o  <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            tick_o  <= 1'b1;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
            tick_o  <= 1'b0;
        end
    end

    logic [N_CH-1:0] raw;
    logic [N_CH-1:0] meta;
    logic [N_CH-1:0] sync;

    assign raw = push_b ^ POLARITY;

    // Plain two-flop chain; nothing may sit between meta and sync.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    for (genvar n = 0; n < N_CH; n++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic             lvl;
        logic             prs;
        logic             rel;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt <= '0;
                lvl <= 1'b0;
                prs <= 1'b0;
                rel <= 1'b0;
            end else begin
                prs <= 1'b0;
                rel <= 1'b0;
                if (tick_o) begin
                    if (sync[n] == lvl) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        lvl <= sync[n];
                        prs <= sync[n];
                        rel <= ~sync[n];
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            end
        end

        assign level_o[n]   = lvl;
        assign press_o[n]   = prs;
        assign release_o[n] = rel;

`ifdef PB_LONG_PRESS_EN
        localparam int LONG_W = $clog2(LONG_CNT + 1);
        localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CNT);
        localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CNT - 1);

        logic [LONG_W-1:0] hold;
        logic              lng;

        // Hold counter saturates at LONG_CNT so the pulse cannot repeat until re-press.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                hold <= '0;
                lng  <= 1'b0;
            end else begin
                lng <= 1'b0;
                if (!lvl) begin
                    hold <= '0;
                end else if (tick_o && hold != LONG_MAX) begin
                    hold <= hold + LONG_W'(1);
                    lng  <= (hold == LONG_LAST);
                end
            end
        end

        assign long_o[n] = lng;
`else
        assign long_o[n] = 1'b0;
`endif
    end

endmodule

// File: doc/push_button_debouncer.md
Name: push_button_debouncer

Overview:
Parametrised multi-channel push-button conditioner.
- Each of N_CH raw button inputs passes through a 2-FF synchroniser on clk_i.
- A tick-sampled counter debounces each synchronised input.
- Outputs per channel: debounced level, single-cycle press pulse and single-cycle release pulse.
- Debounce timing comes from a clock-enable tick, not a derived clock. All logic sits in the clk_i domain and feeds LED and control logic directly.

Parameters:
N_CH, 4, number of independent button channels (1..32)
CLK_HZ, 100000000, clk_i frequency in Hz
TICK_HZ, 1000, debounce sample rate in Hz; DIV = CLK_HZ/TICK_HZ, DIV >= 2 (integer division)
STABLE_CNT, 20, consecutive mismatching ticks required to accept a new level (>= 1)
ACTIVE_LOW, 0, 1 = raw input is inverted before synchronisation (pressed = 0 on the pin)
LONG_CNT, 1000, ticks held pressed before long_o fires (only used with the optional feature)

Ports:
clk_i      input   1     system clock
rst_i      input   1     asynchronous, active-high reset
push_b     input   N_CH  raw asynchronous button inputs
level_o    output  N_CH  debounced pressed state, 1 = pressed
press_o    output  N_CH  1-cycle pulse on accepted press
release_o  output  N_CH  1-cycle pulse on accepted release
long_o     output  N_CH  1-cycle pulse on long press (optional feature)
tick_o     output  1     debounce sample strobe, exported for observation

Behaviour:
- Reset:
  - Asynchronous on rst_i rising; held while rst_i = 1.
  - Clears: prescaler, synchroniser FFs, counters, level_o, press_o, release_o, long_o, tick_o.
  - Release from reset is synchronous to clk_i.
- Prescaler:
  - Counter 0..DIV-1, shared by all channels.
  - tick_o = 1 for exactly one cycle when count == DIV-1, then the counter wraps to 0.
  - First tick comes DIV cycles after reset release.
- Synchroniser:
  - in_n = push_b[n] ^ ACTIVE_LOW.
  - Two flops give sync[n], 2-cycle latency. No logic between the flops.
- Debounce, per channel, evaluated only on tick cycles; counter width = clog2(STABLE_CNT+1):
  - sync == level: counter cleared to 0.
  - sync != level, counter < STABLE_CNT-1: counter increments.
  - sync != level, counter == STABLE_CNT-1: level_o <= sync, counter <= 0.
  - Any single matching tick restarts the count (glitch rejection).
  - Non-tick cycles hold all state.
- Edge pulses:
  - press_o[n] rises on the same edge level_o[n] goes 0->1 and is high exactly one cycle.
  - release_o[n] behaves the same for 1->0.
  - A channel can never assert press_o and release_o together.
  - Channels are fully independent. Simultaneous events on several channels each produce their own pulse in the same cycle.
- Latency: worst case from a stable change on push_b to a level_o change = 2 + STABLE_CNT*DIV cycles.
- Bounce shorter than STABLE_CNT ticks produces no output activity.
- Reset mid-count: the counter is discarded; level_o returns to 0 even if the button is held. A held button is re-accepted as a press STABLE_CNT ticks after reset release.
- Counters saturate by construction; no wrap-around is possible.

Optional Feature:
Macro: PB_LONG_PRESS_EN
- Defined:
  - Per-channel hold counter, width clog2(LONG_CNT+1), cleared while level_o[n] = 0.
  - Increments on each tick while level_o[n] = 1.
  - When it reaches LONG_CNT, long_o[n] pulses for one cycle and the counter saturates. No repeat until release and re-press.
- Not defined: long_o is tied to 0 and no hold counter logic exists.

Test Plan:
All scenarios use CLK_HZ=100, TICK_HZ=10 (DIV=10), STABLE_CNT=3, N_CH=2.
- Reset: hold rst_i = 1 with push_b = 2'b11 -> all outputs 0. Release -> tick_o first high at cycle 10 after release, then every 10 cycles.
- Clean press on ch0: push_b[0] 0->1 held 100 cycles -> level_o[0] = 1 and press_o[0] one-cycle pulse on the 3rd tick after sync (<= 32 cycles). ch1 outputs stay 0.
- Bounce rejection: toggle push_b[0] every 15 cycles for 200 cycles (never 3 consecutive mismatching ticks) -> level_o, press_o and release_o stay 0.
- Release plus simultaneous channels: both inputs pressed and accepted, then both released on the same cycle -> release_o = 2'b11 in one cycle, level_o -> 2'b00.
- ACTIVE_LOW=1: push_b idle at 2'b11 -> level_o = 0. Drive push_b[1] = 0 for 50 cycles -> press_o[1] pulse.
- Long press with PB_LONG_PRESS_EN and LONG_CNT=5: hold ch0 -> long_o[0] pulses once, 5 ticks after level_o[0] rises. Without the macro, long_o stays 0 throughout.
